// File: rtl/ls_preload_loader_pkg.sv
// Shared definitions for the Local Store preload loader.
// Holds the loader FSM state encoding and the Local Store geometry
// that sets the default widths of the loader ports.
package ls_preload_loader_pkg;

  localparam int unsigned LS_QW_BYTES   = 16;
  localparam int unsigned LS_SIZE_BYTES = 32768;

  typedef enum logic [1:0] {
    LDR_IDLE  = 2'd0,
    LDR_FILL  = 2'd1,
    LDR_WRITE = 2'd2,
    LDR_DONE  = 2'd3
  } ldr_state_t;

endpackage

// File: rtl/ls_preload_loader_if.sv
// Word-stream input and Local Store preload write bus of the loader.
//   in_valid/in_data/in_ready : 32-bit word stream (valid/ready)
//   preload_LS_en/addr/data   : one-cycle quadword write strobe to the Local Store
// master: the loader side (consumes words, drives the preload port).
// slave : the environment side (boot source and Local Store).
interface ls_preload_loader_if
  import ls_preload_loader_pkg::*;
#(
  parameter int unsigned LS_ADDR_W = $clog2(LS_SIZE_BYTES)
);
  logic                 in_valid;
  logic [0:31]          in_data;
  logic                 in_ready;
  logic                 preload_LS_en;
  logic [0:LS_ADDR_W-1] preload_LS_addr;
  logic [0:127]         preload_LS_data;

  modport master (
    input  in_valid, in_data,
    output in_ready, preload_LS_en, preload_LS_addr, preload_LS_data
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, preload_LS_en, preload_LS_addr, preload_LS_data
  );
endinterface

// File: rtl/ls_preload_loader_qw_packer.sv
// ls_qw_packer: gathers four 32-bit words into one 128-bit quadword.
//   clk, rst : clock, synchronous active-high reset
//   load     : store word into the next slot
//   word     : incoming word
//   clear    : discard any partial quadword
//   qw       : quadword view, word k at bits [32k:32k+31]; a word being
//              loaded this cycle already appears in its slot
//   full     : this load completes the quadword
module ls_qw_packer (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [0:31]  word,
  input  logic         clear,
  output logic [0:127] qw,
  output logic         full
);
  logic [0:31] slots [4];
  logic [1:0]  wcnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wcnt <= '0;
      for (int unsigned k = 0; k < 4; k++) slots[k] <= '0;
    end else if (load) begin
      slots[wcnt] <= word;
      wcnt        <= wcnt + 2'd1;
    end
  end

  // Bypass the word being accepted so the owner can register the complete
  // quadword on the same edge that takes the fourth word.
  always_comb begin
    qw = '0;
    for (int unsigned k = 0; k < 4; k++)
      qw[32*k +: 32] = (load && wcnt == 2'(k)) ? word : slots[k];
  end

  assign full = load && (wcnt == 2'd3);
endmodule

// File: rtl/ls_preload_loader.sv
// ls_preload_loader: loads a word stream into the Local Store through the
// odd-pipe preload port, one 128-bit write per four accepted words.
//   clk, rst   : clock, synchronous active-high reset
//   start      : one-cycle job request (ignored while a job runs)
//   start_addr : first byte address, low four bits forced to zero
//   qw_count   : quadwords to load (0 completes at once without writing)
//   abort      : cancel the running job, no done pulse
//   bus        : word stream in, preload write port out
//   busy       : job in progress (holds the core)
//   done       : one-cycle pulse on normal completion
module ls_preload_loader
  import ls_preload_loader_pkg::*;
#(
  parameter int unsigned LS_ADDR_W = $clog2(LS_SIZE_BYTES),
  parameter int unsigned QW_CNT_W  = $clog2(LS_SIZE_BYTES / LS_QW_BYTES) + 1,
  parameter int unsigned QW_BYTES  = LS_QW_BYTES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [0:LS_ADDR_W-1] start_addr,
  input  logic [0:QW_CNT_W-1]  qw_count,
  input  logic                 abort,
  ls_preload_loader_if.master  bus,
  output logic                 busy,
  output logic                 done
);
  ldr_state_t state, state_n;

  logic [0:LS_ADDR_W-1] addr_q, addr_n, oaddr_q, oaddr_n;
  logic [0:QW_CNT_W-1]  rem_q, rem_n, rem_dec;
  logic [0:127]         odata_q, odata_n, pk_qw;
  logic                 ready_q, ready_n, en_q, en_n;
  logic                 busy_q, busy_n, done_q, done_n;
  logic                 accept, pk_clear, pk_full;

  // The registered ready is gated by abort so a word offered in the abort
  // cycle is never taken.
  assign bus.in_ready        = ready_q & ~abort;
  assign accept              = bus.in_valid & bus.in_ready;
  assign bus.preload_LS_en   = en_q;
  assign bus.preload_LS_addr = oaddr_q;
  assign bus.preload_LS_data = odata_q;
  assign busy                = busy_q;
  assign done                = done_q;
  assign rem_dec             = rem_q - QW_CNT_W'(1);

  ls_qw_packer u_packer (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .word  (bus.in_data),
    .clear (pk_clear),
    .qw    (pk_qw),
    .full  (pk_full)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= LDR_IDLE;
    else     state <= state_n;
  end

  // Every output is the registered copy of its next value, so each branch
  // describes the outputs seen during the state being entered.
  always_comb begin
    state_n  = state;
    addr_n   = addr_q;
    rem_n    = rem_q;
    oaddr_n  = oaddr_q;
    odata_n  = odata_q;
    ready_n  = 1'b0;
    en_n     = 1'b0;
    busy_n   = 1'b0;
    done_n   = 1'b0;
    pk_clear = 1'b0;
    unique case (state)
      LDR_IDLE: begin
        if (start && !abort) begin
          if (qw_count != '0) begin
            addr_n  = start_addr & ~LS_ADDR_W'(QW_BYTES - 1);
            rem_n   = qw_count;
            state_n = LDR_FILL;
            ready_n = 1'b1;
            busy_n  = 1'b1;
          end else begin
            state_n = LDR_DONE;
            done_n  = 1'b1;
          end
        end
      end
      LDR_FILL: begin
        if (abort) begin
          state_n  = LDR_IDLE;
          rem_n    = '0;
          pk_clear = 1'b1;
        end else begin
          busy_n = 1'b1;
          if (pk_full) begin
            state_n = LDR_WRITE;
            en_n    = 1'b1;
            oaddr_n = addr_q;
            odata_n = pk_qw;
          end else begin
            ready_n = 1'b1;
          end
        end
      end
      LDR_WRITE: begin
        if (abort) begin
          state_n  = LDR_IDLE;
          rem_n    = '0;
          pk_clear = 1'b1;
        end else begin
          addr_n = addr_q + LS_ADDR_W'(QW_BYTES);
          rem_n  = rem_dec;
          if (rem_dec != '0) begin
            state_n = LDR_FILL;
            ready_n = 1'b1;
            busy_n  = 1'b1;
          end else begin
            state_n = LDR_DONE;
            done_n  = 1'b1;
          end
        end
      end
      LDR_DONE: state_n = LDR_IDLE;
      default:  state_n = LDR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      rem_q   <= '0;
      oaddr_q <= '0;
      odata_q <= '0;
      ready_q <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      addr_q  <= addr_n;
      rem_q   <= rem_n;
      oaddr_q <= oaddr_n;
      odata_q <= odata_n;
      ready_q <= ready_n;
      en_q    <= en_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
    end
  end
endmodule
